// File: rtl/usb_cmd_parser.sv
// Receive-side command deframer for ftdi_245fifo: pulls bytes from the FIFO read port,
// checks SYNC/OP/AH/AL/D3..D0/CS frames and presents good frames as valid/ready commands.
module usb_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rd_req,
  input  logic        rd_gnt,
  input  logic [7:0]  rd_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_op,
  output logic [15:0] cmd_addr,
  output logic [31:0] cmd_wdata,
  output logic        err_pulse,
  output logic [15:0] err_cnt
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {HUNT, BODY, CSUM, HOLD} state_t;

  state_t        state, state_nx, eval_state;
  logic [7:0]    skid [2];
  logic [1:0]    skid_cnt, skid_cnt_nx;
  logic [2:0]    idx;
  logic [7:0]    csum;
  logic [55:0]   shreg;
  logic [TW-1:0] idle_cnt;

  logic       pop, push, push_ok, in_valid, timeout;
  logic [7:0] in_byte;
  logic       start, body_shift, good, err_set;

  // Buffered bytes always take precedence over the port so stream order is preserved.
  always_comb begin
    pop         = (state != HOLD) && (skid_cnt != 2'd0);
    push        = rd_gnt && !rd_req;
    push_ok     = push && ((skid_cnt != 2'd2) || pop);
    in_valid    = pop || (rd_req && rd_gnt);
    in_byte     = pop ? skid[0] : rd_data;
    timeout     = ((state == BODY) || (state == CSUM)) && (idle_cnt == TW'(TIMEOUT_CYC));
    skid_cnt_nx = skid_cnt;
    if (push_ok && !pop)      skid_cnt_nx = skid_cnt + 2'd1;
    else if (pop && !push_ok) skid_cnt_nx = skid_cnt - 2'd1;
  end

  always_comb begin
    state_nx   = state;
    start      = 1'b0;
    body_shift = 1'b0;
    good       = 1'b0;
    err_set    = timeout;
    // A timed-out frame is abandoned first, so a byte on that cycle is judged as in HUNT.
    eval_state = timeout ? HUNT : state;
    if (timeout) state_nx = HUNT;
    case (eval_state)
      HUNT: if (in_valid && (in_byte == SYNC_BYTE)) begin
        start    = 1'b1;
        state_nx = BODY;
      end
      BODY: if (in_valid) begin
        body_shift = 1'b1;
        if (idx == 3'd6) state_nx = CSUM;
      end
      CSUM: if (in_valid) begin
        if (in_byte == csum) begin
          good     = 1'b1;
          state_nx = HOLD;
        end else begin
          err_set  = 1'b1;
          state_nx = HUNT;
        end
      end
      HOLD: if (cmd_ready) state_nx = HUNT;
      default: state_nx = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= HUNT;
      rd_req <= 1'b0;
    end else begin
      state  <= state_nx;
      rd_req <= (state_nx != HOLD) && (skid_cnt_nx == 2'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid[0]  <= '0;
      skid[1]  <= '0;
      skid_cnt <= '0;
    end else begin
      if (push_ok && pop) begin
        if (skid_cnt == 2'd1) begin
          skid[0] <= rd_data;
        end else begin
          skid[0] <= skid[1];
          skid[1] <= rd_data;
        end
      end else if (push_ok) begin
        skid[skid_cnt[0]] <= rd_data;
      end else if (pop) begin
        skid[0] <= skid[1];
      end
      skid_cnt <= skid_cnt_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      csum      <= '0;
      shreg     <= '0;
      idle_cnt  <= '0;
      cmd_valid <= 1'b0;
      cmd_op    <= '0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (start || err_set) begin
        idx   <= '0;
        csum  <= '0;
        shreg <= '0;
      end else if (body_shift) begin
        idx   <= idx + 3'd1;
        csum  <= csum ^ in_byte;
        shreg <= {shreg[47:0], in_byte};
      end

      if (in_valid || !((state == BODY) || (state == CSUM)))
        idle_cnt <= '0;
      else if (idle_cnt != TW'(TIMEOUT_CYC))
        idle_cnt <= idle_cnt + TW'(1);

      if (good) begin
        cmd_valid <= 1'b1;
        cmd_op    <= shreg[55:48];
        cmd_addr  <= shreg[47:32];
        cmd_wdata <= shreg[31:0];
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end

      err_pulse <= err_set;
      if (err_set && (err_cnt != '1)) err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_usb_cmd_parser.sv
// Directed bench for usb_cmd_parser: a FIFO read-port model feeds byte frames, and a
// monitor captures handshaken commands and error pulses for comparison.
module tb_usb_cmd_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req;
  logic        rd_gnt = 1'b0;
  logic [7:0]  rd_data = '0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [7:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        err_pulse;
  logic [15:0] err_cnt;

  usb_cmd_parser #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_data(rd_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nerr  = 0;
  int last_acc = 0;
  int lat_meas = -1;
  logic [7:0]  q[$];
  logic [55:0] got_q[$];
  bit lat1 = 1'b0;
  bit prev_req = 1'b0;
  bit rq_now;
  bit prev_valid = 1'b0;
  bit prev_err = 1'b0;
  bit dbl_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // FIFO read-port model: grant from the current request, or one cycle late when lat1 is set.
  initial forever begin
    @(posedge clk); #1;
    if (rst) begin
      rd_gnt   = 1'b0;
      prev_req = 1'b0;
    end else begin
      rq_now = rd_req;
      if ((lat1 ? prev_req : rq_now) && (q.size() > 0)) begin
        rd_data = q.pop_front();
        rd_gnt  = 1'b1;
      end else begin
        rd_gnt = 1'b0;
      end
      prev_req = rq_now;
    end
  end

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst) begin
      if (rd_req && rd_gnt) last_acc = cyc;
      if (cmd_valid && !prev_valid) lat_meas = cyc - last_acc;
      if (cmd_valid && cmd_ready) got_q.push_back({cmd_op, cmd_addr, cmd_wdata});
      if (err_pulse) nerr++;
      if (err_pulse && prev_err) dbl_err = 1'b1;
    end
    prev_valid = cmd_valid;
    prev_err   = err_pulse;
  end

  task automatic send_frame(input logic [7:0] op, input logic [15:0] a,
                            input logic [31:0] d, input bit corrupt);
    logic [7:0] b [7];
    logic [7:0] cs;
    b  = '{op, a[15:8], a[7:0], d[31:24], d[23:16], d[15:8], d[7:0]};
    cs = '0;
    q.push_back(8'hA5);
    for (int i = 0; i < 7; i++) begin
      q.push_back(b[i]);
      cs = cs ^ b[i];
    end
    q.push_back(corrupt ? (cs ^ 8'h01) : cs);
  endtask

  task automatic wait_cmds(input string tag, input int n);
    int k;
    k = 0;
    while ((got_q.size() < n) && (k < 400)) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk(tag, 64'(got_q.size()), 64'(n));
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((q.size() > 0) && (k < 400)) begin
      @(negedge clk);
      k++;
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rd_req"}, 64'(rd_req), 64'd0);
    chk({tag, "_valid"},  64'(cmd_valid), 64'd0);
    chk({tag, "_cmd"},    64'({cmd_op, cmd_addr, cmd_wdata}), 64'd0);
    chk({tag, "_errp"},   64'(err_pulse), 64'd0);
    chk({tag, "_errcnt"}, 64'(err_cnt), 64'd0);
  endtask

  logic [55:0] snap;
  bit          unstable;
  int          e0;
  int          k;

  initial begin
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    chk("rd_req_after_release", 64'(rd_req), 64'd0);
    @(posedge clk); #1;
    chk("rd_req_first_clk", 64'(rd_req), 64'd1);

    // good frame, cs = 05
    send_frame(8'h01, 16'h1234, 32'hDEADBEEF, 1'b0);
    wait_cmds("good_count", 1);
    chk("good_cmd", 64'(got_q[0]), 64'h01_1234_DEADBEEF);
    chk("good_latency", 64'(lat_meas), 64'd1);
    chk("good_errcnt", 64'(err_cnt), 64'd0);

    // corrupted checksum, then a good frame
    got_q.delete();
    send_frame(8'h01, 16'h1234, 32'hDEADBEEF, 1'b1);
    wait_drain();
    chk("bad_cs_nocmd", 64'(got_q.size()), 64'd0);
    chk("bad_cs_pulses", 64'(nerr), 64'd1);
    chk("bad_cs_errcnt", 64'(err_cnt), 64'd1);
    send_frame(8'h7E, 16'h00FF, 32'h0000_0001, 1'b0);
    wait_cmds("after_bad_count", 1);
    chk("after_bad_cmd", 64'(got_q[0]), 64'h7E_00FF_00000001);

    // leading junk
    got_q.delete();
    q.push_back(8'h00); q.push_back(8'hFF); q.push_back(8'h5A);
    send_frame(8'h33, 16'hA5A5, 32'hA5A5A5A5, 1'b0);
    wait_cmds("junk_count", 1);
    chk("junk_cmd", 64'(got_q[0]), 64'h33_A5A5_A5A5A5A5);
    chk("junk_errcnt", 64'(err_cnt), 64'd1);

    // downstream stall with late grants streaming a second frame
    got_q.delete();
    lat1 = 1'b1;
    cmd_ready = 1'b0;
    send_frame(8'h10, 16'h2020, 32'h3030_4040, 1'b0);
    send_frame(8'h02, 16'hABCD, 32'h0123_4567, 1'b0);
    k = 0;
    while (!cmd_valid && (k < 200)) begin @(negedge clk); k++; end
    snap = {cmd_op, cmd_addr, cmd_wdata};
    chk("stall_snap", 64'(snap), 64'h10_2020_30304040);
    unstable = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!cmd_valid || ({cmd_op, cmd_addr, cmd_wdata} != snap)) unstable = 1'b1;
    end
    chk("stall_stable", 64'(unstable), 64'd0);
    chk("stall_rd_req", 64'(rd_req), 64'd0);
    @(posedge clk); #1 cmd_ready = 1'b1;
    wait_cmds("stall_count", 2);
    chk("stall_cmd1", 64'(got_q[0]), 64'h10_2020_30304040);
    chk("stall_cmd2", 64'(got_q[1]), 64'h02_ABCD_01234567);
    lat1 = 1'b0;

    // timeout after a partial frame
    got_q.delete();
    e0 = nerr;
    q.push_back(8'hA5); q.push_back(8'h01); q.push_back(8'h12);
    repeat (40) @(negedge clk);
    chk("timeout_pulses", 64'(nerr - e0), 64'd1);
    chk("timeout_errcnt", 64'(err_cnt), 64'd2);
    chk("timeout_nocmd", 64'(got_q.size()), 64'd0);
    send_frame(8'h01, 16'h1234, 32'hDEADBEEF, 1'b0);
    wait_cmds("timeout_next_count", 1);
    chk("timeout_next_cmd", 64'(got_q[0]), 64'h01_1234_DEADBEEF);

    // reset mid-frame
    got_q.delete();
    q.push_back(8'hA5); q.push_back(8'h01); q.push_back(8'h12); q.push_back(8'h34);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("rst_mid");
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_frame(8'h44, 16'h5566, 32'h7788_99AA, 1'b0);
    wait_cmds("rst_mid_count", 1);
    chk("rst_mid_cmd", 64'(got_q[0]), 64'h44_5566_778899AA);

    // reset while holding a command
    got_q.delete();
    cmd_ready = 1'b0;
    send_frame(8'hC3, 16'hBEEF, 32'hCAFE_F00D, 1'b0);
    k = 0;
    while (!cmd_valid && (k < 200)) begin @(negedge clk); k++; end
    chk("hold_reached", 64'(cmd_valid), 64'd1);
    #2 rst = 1'b1;
    #1 check_reset_vals("rst_hold");
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmd_ready = 1'b1;
    send_frame(8'h5A, 16'h0102, 32'h0304_0506, 1'b0);
    wait_cmds("rst_hold_count", 1);
    chk("rst_hold_cmd", 64'(got_q[0]), 64'h5A_0102_03040506);

    chk("err_single_cycle", 64'(dbl_err), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
